// File: rtl/riscv_pkg.sv
// Shared types and constants for the single-cycle RISC-V test harness.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_AW       = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RST,
    S_RUN,
    S_CHECK,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/regfile_checker.sv
// Walks the expected-value table one entry per cycle while enabled,
// comparing the debug register read against it and capturing the first fail.
module regfile_checker
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned NUM_CHECKS = 3,
  parameter int unsigned CA         = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            check_en,
  input  logic [XLEN-1:0] dbg_rdata,
  input  logic [XLEN-1:0] chk_val,
  output logic [CA-1:0]   chk_idx,
  output logic [CA-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_value,
  output logic            pass,
  output logic            check_done
);

  logic match;
  logic last;

  // Compare the current entry and decide whether this cycle ends the scan.
  always_comb begin
    match      = (dbg_rdata == chk_val);
    last       = (chk_idx == CA'(NUM_CHECKS - 1));
    check_done = check_en && (!match || last);
  end

  // Index counter plus first-mismatch / all-pass capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_idx    <= '0;
      fail_idx   <= '0;
      fail_value <= '0;
      pass       <= 1'b0;
    end else if (clear) begin
      chk_idx    <= '0;
      fail_idx   <= '0;
      fail_value <= '0;
      pass       <= 1'b0;
    end else if (check_en) begin
      chk_idx <= check_done ? '0 : chk_idx + 1'b1;
      if (!match) begin
        fail_idx   <= chk_idx;
        fail_value <= dbg_rdata;
      end else if (last) begin
        pass <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_test_sequencer.sv
// Test sequencer for the single-cycle RISC-V core: loads imem from a ROM,
// clears dmem, pulses core reset, runs the core, then scans the register file.
module riscv_test_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned IMEM_DEPTH   = 64,
  parameter int unsigned DMEM_DEPTH   = 64,
  parameter int unsigned NUM_CHECKS   = 3,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 50,
  localparam int unsigned IA = $clog2(IMEM_DEPTH),
  localparam int unsigned DA = $clog2(DMEM_DEPTH),
  localparam int unsigned CA = ($clog2(NUM_CHECKS) > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int unsigned CW = $clog2(RUN_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IA-1:0]     prog_addr,
  input  logic [XLEN-1:0]   prog_data,
  output logic              imem_we,
  output logic [IA-1:0]     imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              dmem_we,
  output logic [DA-1:0]     dmem_waddr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic              core_reset,
  output logic              core_en,
  input  logic              core_halt,
  output logic [CA-1:0]     chk_idx,
  input  logic [REG_AW-1:0] chk_reg,
  input  logic [XLEN-1:0]   chk_val,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [XLEN-1:0]   dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              halted,
  output logic [CA-1:0]     fail_idx,
  output logic [XLEN-1:0]   fail_value,
  output logic [CW-1:0]     cycle_count
);

  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

  seq_state_t      state_q, state_d;
  logic [DA-1:0]   clr_cnt;
  logic [RW-1:0]   rst_cnt;
  logic            start_ok;
  logic            check_en;
  logic            check_done;
  logic            load_last, clear_last, rst_last, run_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    load_last  = (prog_addr == IA'(IMEM_DEPTH - 1));
    clear_last = (clr_cnt == DA'(DMEM_DEPTH - 1));
    rst_last   = (rst_cnt == RW'(RESET_CYCLES - 1));
    run_last   = (cycle_count == CW'(RUN_CYCLES - 1));
    start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    check_en   = (state_q == S_CHECK);
    core_reset = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                 (state_q == S_CLEAR) || (state_q == S_RST);
    core_en    = (state_q == S_RUN);
    busy       = !((state_q == S_IDLE) || (state_q == S_DONE));
    done       = (state_q == S_DONE);
    dmem_we    = (state_q == S_CLEAR);
    dmem_waddr = clr_cnt;
    dmem_wdata = '0;
    // ROM output is already one cycle late, so it lines up with the registered address.
    imem_wdata = imem_we ? prog_data : '0;
    dbg_raddr  = check_en ? chk_reg : '0;

    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD:         if (load_last) state_d = S_CLEAR;
      S_CLEAR:        if (clear_last) state_d = S_RST;
      S_RST:          if (rst_last) state_d = S_RUN;
      S_RUN:          if (core_halt || run_last) state_d = S_CHECK;
      S_CHECK:        if (check_done) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Load pipeline, clear / reset-hold / run counters and halt capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_addr   <= '0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      clr_cnt     <= '0;
      rst_cnt     <= '0;
      cycle_count <= '0;
      halted      <= 1'b0;
    end else begin
      imem_we    <= (state_q == S_LOAD);
      imem_waddr <= prog_addr;

      if (start_ok) prog_addr <= '0;
      else if (state_q == S_LOAD) prog_addr <= load_last ? '0 : prog_addr + 1'b1;

      if (start_ok) clr_cnt <= '0;
      else if (state_q == S_CLEAR) clr_cnt <= clear_last ? '0 : clr_cnt + 1'b1;

      if (start_ok) rst_cnt <= '0;
      else if (state_q == S_RST) rst_cnt <= rst_last ? '0 : rst_cnt + 1'b1;

      if (start_ok) cycle_count <= '0;
      else if (state_q == S_RUN) cycle_count <= cycle_count + 1'b1;

      if (start_ok) halted <= 1'b0;
      else if (state_q == S_RUN && core_halt) halted <= 1'b1;
    end
  end

  regfile_checker #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS),
    .CA         (CA)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .check_en   (check_en),
    .dbg_rdata  (dbg_rdata),
    .chk_val    (chk_val),
    .chk_idx    (chk_idx),
    .fail_idx   (fail_idx),
    .fail_value (fail_value),
    .pass       (pass),
    .check_done (check_done)
  );

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Directed bench for riscv_test_sequencer with a tiny ROM, table and core model.
module tb_riscv_test_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IMEM_DEPTH = 4;
  localparam int unsigned DMEM_DEPTH = 4;
  localparam int unsigned NUM_CHECKS = 3;
  localparam int unsigned RESET_CYCLES = 2;
  localparam int unsigned RUN_CYCLES = 50;
  localparam int unsigned IA = 2;
  localparam int unsigned DA = 2;
  localparam int unsigned CA = 2;
  localparam int unsigned CW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [IA-1:0]   prog_addr;
  logic [XLEN-1:0] prog_data;
  logic            imem_we;
  logic [IA-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            dmem_we;
  logic [DA-1:0]   dmem_waddr;
  logic [XLEN-1:0] dmem_wdata;
  logic            core_reset;
  logic            core_en;
  logic            core_halt;
  logic [CA-1:0]   chk_idx;
  logic [4:0]      chk_reg;
  logic [XLEN-1:0] chk_val;
  logic [4:0]      dbg_raddr;
  logic [XLEN-1:0] dbg_rdata;
  logic            busy, done, pass, halted;
  logic [CA-1:0]   fail_idx;
  logic [XLEN-1:0] fail_value;
  logic [CW-1:0]   cycle_count;

  int n_cmp = 0;
  int n_fail = 0;

  riscv_test_sequencer #(
    .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH),
    .NUM_CHECKS(NUM_CHECKS), .RESET_CYCLES(RESET_CYCLES), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .core_reset(core_reset), .core_en(core_en), .core_halt(core_halt),
    .chk_idx(chk_idx), .chk_reg(chk_reg), .chk_val(chk_val),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .busy(busy), .done(done), .pass(pass), .halted(halted),
    .fail_idx(fail_idx), .fail_value(fail_value), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Program ROM with one cycle read latency.
  logic [XLEN-1:0] rom [4] = '{32'h00500293, 32'h00C00313, 32'h006283B3, 32'h00000013};
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Expected-value table.
  always_comb begin
    chk_reg = 5'd0;
    chk_val = '0;
    case (chk_idx)
      2'd0: begin chk_reg = 5'd5; chk_val = 32'h8;  end
      2'd1: begin chk_reg = 5'd6; chk_val = 32'h14; end
      2'd2: begin chk_reg = 5'd7; chk_val = 32'h14; end
      default: ;
    endcase
  end

  // Core model: writes result registers while enabled, optional halt on 10th run cycle.
  logic            bad_x6 = 1'b0;
  logic            halt_mode = 1'b0;
  logic [XLEN-1:0] regs [32];
  int unsigned     core_cycles = 0;
  always @(posedge clk) begin
    if (core_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      core_cycles <= 0;
    end else if (core_en) begin
      regs[5] <= 32'h8;
      regs[6] <= bad_x6 ? 32'h13 : 32'h14;
      regs[7] <= 32'h14;
      core_cycles <= core_cycles + 1;
    end
  end
  assign core_halt = halt_mode && (core_cycles == 9);
  assign dbg_rdata = regs[dbg_raddr];

  // Cycle counter and write-port monitors, sampled on the falling edge.
  int unsigned     cyc = 0;
  int unsigned     imem_cyc [4];
  logic [XLEN-1:0] imem_data [4];
  int unsigned     dmem_cyc [4];
  int unsigned     dmem_total = 0;
  int unsigned     dmem_nonzero = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (imem_we) begin
      imem_cyc[imem_waddr]  <= cyc;
      imem_data[imem_waddr] <= imem_wdata;
    end
    if (dmem_we) begin
      dmem_cyc[dmem_waddr] <= cyc;
      dmem_total <= dmem_total + 1;
      if (dmem_wdata != '0) dmem_nonzero <= dmem_nonzero + 1;
    end
  end

  task automatic pulse_start(output int unsigned s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(output int unsigned run_len, output int unsigned chk_len,
                             output bit ok);
    run_len = 0;
    chk_len = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (core_en) run_len++;
      if (busy && !core_en && !core_reset) chk_len++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({core_reset, core_en, busy, done, pass, halted} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100000", {core_reset, core_en, busy, done, pass, halted});
    end
    n_cmp++;
    if ({prog_addr, imem_we, imem_waddr, dmem_we, dmem_waddr, chk_idx, dbg_raddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_ports: got %h want 0", {prog_addr, imem_we, imem_waddr, dmem_we, dmem_waddr, chk_idx, dbg_raddr});
    end
    n_cmp++;
    if ({imem_wdata, dmem_wdata, fail_idx, fail_value, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {imem_wdata, dmem_wdata, fail_idx, fail_value, cycle_count});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, core_reset, imem_we} !== 3'b010) begin
      n_fail++;
      $display("FAIL idle_hold: got %b want 010", {busy, core_reset, imem_we});
    end
  endtask

  task automatic test_load_pass;
    int unsigned s, run_len, chk_len, dbase;
    bit ok;
    dbase = dmem_total;
    pulse_start(s);
    run_to_done(run_len, chk_len, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL load_pass_timeout: got no done want done"); end
    for (int a = 0; a < 4; a++) begin
      n_cmp++;
      if (imem_cyc[a] !== s + 2 + a || imem_data[a] !== rom[a]) begin
        n_fail++;
        $display("FAIL imem_write[%0d]: got cyc %0d data %h want cyc %0d data %h",
                 a, imem_cyc[a] - s, imem_data[a], 2 + a, rom[a]);
      end
      n_cmp++;
      if (dmem_cyc[a] !== s + 5 + a) begin
        n_fail++;
        $display("FAIL dmem_write[%0d]: got cyc %0d want %0d", a, dmem_cyc[a] - s, 5 + a);
      end
    end
    n_cmp++;
    if (dmem_total - dbase !== 4 || dmem_nonzero !== 0) begin
      n_fail++;
      $display("FAIL dmem_clear: got %0d writes %0d nonzero want 4 writes 0 nonzero",
               dmem_total - dbase, dmem_nonzero);
    end
    n_cmp++;
    if ({pass, halted} !== 2'b10 || cycle_count !== 6'd50 || run_len !== 50 || chk_len !== 3) begin
      n_fail++;
      $display("FAIL pass_run: got pass %b halted %b count %0d run %0d chk %0d want 1 0 50 50 3",
               pass, halted, cycle_count, run_len, chk_len);
    end
    n_cmp++;
    if ({core_reset, core_en, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL done_core_ctl: got %b want 000", {core_reset, core_en, busy});
    end
  endtask

  task automatic test_mismatch;
    int unsigned s, run_len, chk_len;
    bit ok;
    bad_x6 = 1'b1;
    pulse_start(s);
    run_to_done(run_len, chk_len, ok);
    bad_x6 = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL mismatch_timeout: got no done want done"); end
    n_cmp++;
    if (pass !== 1'b0 || fail_idx !== 2'd1 || fail_value !== 32'h13 || chk_len !== 2) begin
      n_fail++;
      $display("FAIL mismatch: got pass %b idx %0d val %h chk %0d want 0 1 13 2",
               pass, fail_idx, fail_value, chk_len);
    end
  endtask

  task automatic test_halt;
    int unsigned s, run_len, chk_len;
    bit ok;
    halt_mode = 1'b1;
    pulse_start(s);
    run_to_done(run_len, chk_len, ok);
    halt_mode = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL halt_timeout: got no done want done"); end
    n_cmp++;
    if (halted !== 1'b1 || cycle_count !== 6'd10 || run_len !== 10 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL halt: got halted %b count %0d run %0d pass %b want 1 10 10 1",
               halted, cycle_count, run_len, pass);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned s, run_len, chk_len;
    bit ok;
    pulse_start(s);
    n_cmp++;
    if ({done, busy, halted, pass} !== 4'b0100 || cycle_count !== '0) begin
      n_fail++;
      $display("FAIL rerun_clear: got done %b busy %b halted %b pass %b count %0d want 0 1 0 0 0",
               done, busy, halted, pass, cycle_count);
    end
    run_to_done(run_len, chk_len, ok);
    n_cmp++;
    if (!ok || pass !== 1'b1 || halted !== 1'b0 || cycle_count !== 6'd50 || imem_cyc[0] !== s + 2) begin
      n_fail++;
      $display("FAIL rerun_result: got ok %b pass %b halted %b count %0d want 1 1 0 50",
               ok, pass, halted, cycle_count);
    end
  endtask

  task automatic test_start_during_run;
    int unsigned s, run_len, chk_len;
    bit ok, seen;
    pulse_start(s);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_en) begin seen = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    run_to_done(run_len, chk_len, ok);
    n_cmp++;
    if (!seen || !ok || cycle_count !== 6'd50 || pass !== 1'b1 || imem_cyc[0] !== s + 2) begin
      n_fail++;
      $display("FAIL start_in_run: got seen %b ok %b count %0d pass %b load_cyc %0d want 1 1 50 1 2",
               seen, ok, cycle_count, pass, imem_cyc[0] - s);
    end
  endtask

  task automatic test_reset_mid_load;
    int unsigned s, run_len, chk_len, writes;
    bit ok;
    pulse_start(s);
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_we) writes++;
      if (writes == 2) break;
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_we, core_reset, busy, done, pass} !== 5'b01000 || prog_addr !== '0) begin
      n_fail++;
      $display("FAIL mid_load_abort: got we %b crst %b busy %b done %b pass %b addr %0d want 0 1 0 0 0 0",
               imem_we, core_reset, busy, done, pass, prog_addr);
    end
    reset = 1'b0;
    pulse_start(s);
    run_to_done(run_len, chk_len, ok);
    n_cmp++;
    if (!ok || imem_cyc[0] !== s + 2 || imem_cyc[3] !== s + 5 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL reload: got ok %b cyc0 %0d cyc3 %0d pass %b want 1 2 5 1",
               ok, imem_cyc[0] - s, imem_cyc[3] - s, pass);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset;
    test_load_pass;
    test_mismatch;
    test_halt;
    test_back_to_back;
    test_start_during_run;
    test_reset_mid_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
